// File: rtl/uart_boot_loader_p.sv
// UART boot loader: fills an external RAM from an 8N1 serial stream after reset,
// replies with a byte checksum, then dumps the RAM back over tx on a scan request.
module uart_boot_loader_p #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int LOAD_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              rx,
  input  logic              scan_memory,
  input  logic [DATA_W-1:0] ram_in,
  output logic              tx,
  output logic              boot,
  output logic [DATA_W-1:0] ram_out,
  output logic [ADDR_W-1:0] ram_adr,
  output logic              ram_rw,
  output logic              ram_enable,
  output logic              err
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  BIT_END   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  HALF_END  = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);

  typedef enum logic [3:0] {
    S_LOAD, S_LOAD_WR, S_CKSUM, S_CKSUM_WAIT, S_IDLE,
    S_SCAN_RD, S_SCAN_WAIT, S_SCAN_TX, S_SCAN_TXW
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [CNT_W-1:0]   lane, lane_n;
  logic [7:0]         cksum, cksum_n;
  logic [DATA_W-1:0]  word, word_n;
  logic [DATA_W-1:0]  rd_word, rd_word_n;

  logic rx_s1, rx_s2, rx_d;
  logic scan_s1, scan_s2, scan_d;
  logic scan_rise;

  logic             rx_busy, rx_valid;
  logic [3:0]       rx_bit;
  logic [DIV_W-1:0] rx_cnt;
  logic [7:0]       rx_sh;

  logic             tx_busy, tx_start;
  logic [3:0]       tx_bit;
  logic [DIV_W-1:0] tx_cnt;
  logic [8:0]       tx_sh;
  logic [7:0]       tx_data;

  // Two-flop synchronisers for rx and scan_memory, plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rx_s1, rx_s2, rx_d}       <= 3'b111;
      {scan_s1, scan_s2, scan_d} <= 3'b000;
    end else if (ce) begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_d    <= rx_s2;
      scan_s1 <= scan_memory;
      scan_s2 <= scan_s1;
      scan_d  <= scan_s2;
    end
  end

  assign scan_rise = scan_s2 & ~scan_d;

  // UART receiver: rx_bit 0 = start check, 1..8 = data, 9 = stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_busy  <= 1'b0;
      rx_valid <= 1'b0;
      rx_bit   <= '0;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      err      <= 1'b0;
    end else if (ce) begin
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_d && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_bit  <= '0;
          rx_cnt  <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          if (rx_s2) rx_busy <= 1'b0;
          else       rx_bit  <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (rx_cnt == BIT_END) begin
        rx_cnt <= '0;
        if (rx_bit <= 4'd8) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
        end else begin
          rx_busy <= 1'b0;
          if (rx_s2) rx_valid <= 1'b1;
          else       err      <= 1'b1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  // UART transmitter: start bit on accept, then 8 data bits and stop shifted out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_bit  <= '0;
      tx_cnt  <= '0;
      tx_sh   <= '1;
    end else if (ce) begin
      if (!tx_busy) begin
        if (tx_start) begin
          tx_busy <= 1'b1;
          tx      <= 1'b0;
          tx_sh   <= {1'b1, tx_data};
          tx_bit  <= '0;
          tx_cnt  <= '0;
        end
      end else if (tx_cnt == BIT_END) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx     <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // Control FSM state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_LOAD;
      addr    <= '0;
      lane    <= '0;
      cksum   <= '0;
      word    <= '0;
      rd_word <= '0;
    end else if (ce) begin
      state   <= state_n;
      addr    <= addr_n;
      lane    <= lane_n;
      cksum   <= cksum_n;
      word    <= word_n;
      rd_word <= rd_word_n;
    end
  end

  // Next-state logic: load words, send checksum, then serve scan dumps
  always_comb begin
    state_n   = state;
    addr_n    = addr;
    lane_n    = lane;
    cksum_n   = cksum;
    word_n    = word;
    rd_word_n = rd_word;
    tx_start  = 1'b0;
    tx_data   = cksum;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (lane == CNT_W'(i)) tx_data = rd_word[8*i +: 8];
    end
    case (state)
      S_LOAD: begin
        if (rx_valid) begin
          for (int unsigned i = 0; i < BYTES; i++) begin
            if (lane == CNT_W'(i)) word_n[8*i +: 8] = rx_sh;
          end
          cksum_n = cksum + rx_sh;
          if (lane == LAST_LANE) begin
            lane_n  = '0;
            state_n = S_LOAD_WR;
          end else begin
            lane_n = lane + 1'b1;
          end
        end
      end
      S_LOAD_WR: begin
        addr_n  = addr + 1'b1;
        state_n = (addr == LAST_ADDR) ? S_CKSUM : S_LOAD;
      end
      S_CKSUM: begin
        tx_start = 1'b1;
        tx_data  = cksum;
        state_n  = S_CKSUM_WAIT;
      end
      S_CKSUM_WAIT: begin
        if (!tx_busy) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (scan_rise) begin
          addr_n  = '0;
          lane_n  = '0;
          state_n = S_SCAN_RD;
        end
      end
      S_SCAN_RD: state_n = S_SCAN_WAIT;
      S_SCAN_WAIT: begin
        rd_word_n = ram_in;
        lane_n    = '0;
        state_n   = S_SCAN_TX;
      end
      S_SCAN_TX: begin
        tx_start = 1'b1;
        state_n  = S_SCAN_TXW;
      end
      S_SCAN_TXW: begin
        if (!tx_busy) begin
          if (lane == LAST_LANE) begin
            lane_n  = '0;
            addr_n  = addr + 1'b1;
            state_n = (addr == LAST_ADDR) ? S_IDLE : S_SCAN_RD;
          end else begin
            lane_n  = lane + 1'b1;
            state_n = S_SCAN_TX;
          end
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  // RAM strobes are decoded from the state so each access lasts exactly one ce-cycle
  assign ram_enable = (state == S_LOAD_WR) || (state == S_SCAN_RD);
  assign ram_rw     = (state == S_LOAD_WR);
  assign ram_adr    = addr;
  assign ram_out    = word;
  assign boot       = (state == S_LOAD) || (state == S_LOAD_WR);

endmodule

// File: tb/tb_uart_boot_loader_p.sv
// Directed bench for uart_boot_loader_p with a RAM model and scoreboard queues
// for RAM writes, RAM reads and transmitted bytes.
module tb_uart_boot_loader_p;

  localparam int CLK_DIV    = 8;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 2;
  localparam int LOAD_WORDS = 4;

  logic              clk = 1'b0;
  logic              rst, ce, rx, scan_memory;
  logic [DATA_W-1:0] ram_in;
  logic              tx, boot, ram_rw, ram_enable, err;
  logic [DATA_W-1:0] ram_out;
  logic [ADDR_W-1:0] ram_adr;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W+DATA_W-1:0] exp_wr[$];
  logic [ADDR_W-1:0]        exp_rd[$];
  logic [7:0]               exp_tx[$];

  logic [DATA_W-1:0] mem [LOAD_WORDS];
  logic [7:0] img [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
  logic [7:0] tm_byte;

  uart_boot_loader_p #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_WORDS(LOAD_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .rx(rx), .scan_memory(scan_memory), .ram_in(ram_in),
    .tx(tx), .boot(boot), .ram_out(ram_out), .ram_adr(ram_adr), .ram_rw(ram_rw),
    .ram_enable(ram_enable), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // RAM model: synchronous write, read data one cycle after the strobe
  always @(posedge clk) begin
    if (ce && ram_enable) begin
      if (ram_rw) mem[ram_adr] <= ram_out;
      else        ram_in <= mem[ram_adr];
    end
  end

  // RAM access scoreboard
  always @(negedge clk) begin
    if (!rst && ce && ram_enable) begin
      if (ram_rw) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $error("FAIL unexpected_write adr=%0d data=0x%0h expected=none", ram_adr, ram_out);
        end else chk("ram_write", 32'({ram_adr, ram_out}), 32'(exp_wr.pop_front()));
      end else begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $error("FAIL unexpected_read adr=%0d expected=none", ram_adr);
        end else chk("ram_read_adr", 32'(ram_adr), 32'(exp_rd.pop_front()));
      end
    end
  end

  // Serial decoder on tx
  always begin
    @(negedge tx);
    repeat (CLK_DIV / 2) @(negedge clk);
    chk("tx_start_bit", 32'(tx), 32'(0));
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      tm_byte[i] = tx;
    end
    repeat (CLK_DIV) @(negedge clk);
    chk("tx_stop_bit", 32'(tx), 32'(1));
    if (exp_tx.size() == 0) begin
      checks++; errors++;
      $error("FAIL unexpected_tx observed=0x%0h expected=none", tm_byte);
    end else chk("tx_byte", 32'(tm_byte), 32'(exp_tx.pop_front()));
  end

  // One 8N1 frame followed by two idle bit times; optional ce stall in the middle of one bit
  task automatic send_byte(input logic [7:0] d, input logic stop, input int stall_bit);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = frame[i];
      if (i == stall_bit) begin
        repeat (CLK_DIV / 2) @(negedge clk);
        ce = 1'b0;
        repeat (20) @(negedge clk);
        ce = 1'b1;
        repeat (CLK_DIV / 2 - 1) @(negedge clk);
      end else begin
        repeat (CLK_DIV - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic load_image(input bit with_bad, input int stall_byte);
    logic [7:0] sum;
    sum = '0;
    for (int k = 0; k < 8; k++) begin
      if (with_bad && k == 2) begin
        send_byte(8'hAA, 1'b0, -1);
        chk("framing_err", 32'(err), 32'(1));
      end
      if (k % 2 == 1) exp_wr.push_back({ADDR_W'(k / 2), img[k], img[k-1]});
      sum = sum + img[k];
      if (k == 7) exp_tx.push_back(sum);
      send_byte(img[k], 1'b1, (k == stall_byte) ? 5 : -1);
    end
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_wr.size() == 0 && exp_rd.size() == 0 && exp_tx.size() == 0) break;
      @(negedge clk);
    end
    chk({tag, "_wr_left"}, 32'(exp_wr.size()), 32'(0));
    chk({tag, "_rd_left"}, 32'(exp_rd.size()), 32'(0));
    chk({tag, "_tx_left"}, 32'(exp_tx.size()), 32'(0));
    repeat (3 * CLK_DIV) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; rx = 1'b1; scan_memory = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_boot", 32'(boot), 32'(1));
    chk("rst_ram_enable", 32'(ram_enable), 32'(0));
    chk("rst_ram_rw", 32'(ram_rw), 32'(0));
    chk("rst_ram_adr", 32'(ram_adr), 32'(0));
    chk("rst_ram_out", 32'(ram_out), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    rst = 1'b0;

    // Two-cycle low glitch on rx must not produce a byte or an error
    repeat (5) @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CLK_DIV) @(negedge clk);
    chk("glitch_err", 32'(err), 32'(0));
    chk("glitch_boot", 32'(boot), 32'(1));

    // Full load with a framing-error byte inserted between words
    load_image(1'b1, -1);
    wait_drain("load", 3000);
    chk("load_boot", 32'(boot), 32'(0));
    chk("load_err_sticky", 32'(err), 32'(1));

    // A byte received in IDLE must be ignored
    send_byte(8'h55, 1'b1, -1);
    chk("idle_boot", 32'(boot), 32'(0));

    // Scan dump reads every word and sends low lane first
    for (int a = 0; a < LOAD_WORDS; a++) exp_rd.push_back(ADDR_W'(a));
    for (int k = 0; k < 8; k++) exp_tx.push_back(img[k]);
    @(negedge clk);
    scan_memory = 1'b1;
    repeat (4) @(negedge clk);
    scan_memory = 1'b0;
    wait_drain("scan", 3000);

    // Asynchronous reset between clock edges takes effect immediately
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_tx", 32'(tx), 32'(1));
    chk("async_boot", 32'(boot), 32'(1));
    chk("async_ram_enable", 32'(ram_enable), 32'(0));
    chk("async_err", 32'(err), 32'(0));
    chk("async_ram_adr", 32'(ram_adr), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Partial load aborted by reset, then full reload with a ce stall inside byte 2
    exp_wr.push_back({ADDR_W'(0), img[1], img[0]});
    send_byte(img[0], 1'b1, -1);
    send_byte(img[1], 1'b1, -1);
    send_byte(img[2], 1'b1, -1);
    chk("partial_wr_left", 32'(exp_wr.size()), 32'(0));
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reload_adr", 32'(ram_adr), 32'(0));
    chk("reload_boot", 32'(boot), 32'(1));
    load_image(1'b0, 2);
    wait_drain("reload", 3000);
    chk("reload_boot_done", 32'(boot), 32'(0));
    chk("reload_err", 32'(err), 32'(0));
    for (int a = 0; a < LOAD_WORDS; a++)
      chk("reload_mem", 32'(mem[a]), 32'({img[2*a+1], img[2*a]}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
